fifo_burst_reader: RTL and testbench

- Read-side consumer for the synchronous 32-bit FIFO.
- Runs in the FIFO read clock domain: `clk` is tied to the divided read clock.
- On a start command it pops exactly `burst_len` words from the FIFO (1-cycle registered read latency) and forwards them on a valid/ready stream through an internal 3-entry skid buffer.
- Pulses `done` once every word of the burst has been accepted downstream.

---
 rtl/fifo_burst_reader.sv | 129 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a requested number of words from a synchronous FIFO and
// forwards them on a valid/ready stream through a 3-entry fall-through skid buffer.
module fifo_burst_reader #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_read,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  words_inc;
  logic              inflight;

  logic [DATA_W-1:0] skid_mem [3];
  logic [1:0]        head;
  logic [1:0]        count;
  logic [1:0]        tail;
  logic [1:0]        head_inc;
  logic [2:0]        tail_sum;
  logic [2:0]        occupancy;
  logic              skid_nonempty;
  logic              handshake;
  logic              pop_head;
  logic              push_tail;

  // The in-flight word is presented straight from the FIFO when the buffer is
  // empty, so the first word reaches the stream on the cycle it arrives.
  always_comb begin
    skid_nonempty = (count != 2'd0);
    occupancy     = {1'b0, count} + {2'b00, inflight};
    fifo_rd_en    = (state == S_RUN) && !fifo_empty && (issued < len_q) && (occupancy < 3'd3);
    m_valid       = skid_nonempty || inflight;
    m_data        = skid_nonempty ? skid_mem[head] : fifo_data;
    handshake     = m_valid && m_ready;
    pop_head      = handshake && skid_nonempty;
    push_tail     = inflight && !(handshake && !skid_nonempty);
    tail_sum      = {1'b0, head} + {1'b0, count};
    tail          = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];
    head_inc      = (head == 2'd2) ? 2'd0 : head + 2'd1;
    words_inc     = words_read + LEN_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= 2'd0;
      count <= 2'd0;
    end else begin
      if (pop_head) head <= head_inc;
      case ({push_tail, pop_head})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_tail) skid_mem[tail] <= fifo_data;
  end

  // DONE is entered on the edge that registers the final handshake, so done
  // appears the cycle right after it with words_read already complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      len_q      <= '0;
      issued     <= '0;
      words_read <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + LEN_ONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= burst_len;
            issued     <= '0;
            words_read <= '0;
            busy       <= 1'b1;
            if (burst_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (handshake && (words_read != len_q)) words_read <= words_inc;
          if ((words_read == len_q) || (handshake && (words_inc == len_q))) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and a
// monitor compares every stream word and every done pulse against queued expectations.
module tb_fifo_burst_reader;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_read;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .words_read (words_read),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: words are appended by the stimulus, popped with one cycle of read latency.
  logic [DATA_W-1:0] fifo_mem [4096];
  int wr_total = 0;
  int rd_total = 0;
  int cyc = 0;

  assign fifo_empty = (rd_total == wr_total);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rd_total <= wr_total;
    else if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_total];
      rd_total  <= rd_total + 1;
    end
  end

  logic [DATA_W-1:0] exp_mem [4096];
  int exp_wr = 0, exp_rd = 0;
  int exp_len [64];
  int len_wr = 0, len_rd = 0;

  int errors = 0, checks = 0;
  int rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int first_rd, last_rd, first_hs, last_hs, done_cyc;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  int c0, done_target, loaded, len_r, n;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected event or timeout, expected clean completion", name);
  endtask

  task automatic loadWords(input int cnt);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      fifo_mem[wr_total] = w;
      exp_mem[exp_wr]    = w;
      wr_total++;
      exp_wr++;
    end
  endtask

  task automatic applyStimulus(input int len);
    exp_len[len_wr] = len;
    len_wr++;
    rd_cnt      = 0;
    hs_cnt      = 0;
    done_target = done_cnt + 1;
    start       = 1'b1;
    burst_len   = LEN_W'(len);
    c0          = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k;
    k = 0;
    while (done_cnt < done_target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt < done_target) failNow("done_timeout");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_rd     = exp_wr;
          len_rd     = len_wr;
          prev_stall = 1'b0;
        end else begin
          if (fifo_rd_en) begin
            checkOutput("rd_en_while_empty", {31'b0, fifo_empty}, 32'd0);
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
          end
          if (prev_stall) begin
            checkOutput("stall_valid", {31'b0, m_valid}, 32'd1);
            checkOutput("stall_data", m_data, prev_data);
          end
          if (m_valid && m_ready) begin
            if (exp_rd < exp_wr) begin
              checkOutput("stream_data", m_data, exp_mem[exp_rd]);
              exp_rd++;
            end else failNow("stream_unexpected_word");
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
          end
          if (done) begin
            if (len_rd < len_wr) begin
              checkOutput("done_words_read", 32'(words_read), 32'(exp_len[len_rd]));
              checkOutput("done_all_words_seen", 32'(exp_rd), 32'(exp_wr));
              len_rd++;
            end else failNow("done_unexpected");
            done_cyc = cyc;
            done_cnt++;
          end
          prev_stall = m_valid && !m_ready;
          prev_data  = m_data;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_words_read", 32'(words_read), 32'd0);
    checkOutput("reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("reset_m_valid", {31'b0, m_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back burst of 4 with the sink always ready.
    m_ready = 1'b1;
    loadWords(4);
    applyStimulus(4);
    waitDone(50);
    checkOutput("b4_first_rd", 32'(first_rd), 32'(c0 + 1));
    checkOutput("b4_rd_count", 32'(rd_cnt), 32'd4);
    checkOutput("b4_last_rd", 32'(last_rd), 32'(c0 + 4));
    checkOutput("b4_first_hs", 32'(first_hs), 32'(c0 + 2));
    checkOutput("b4_last_hs", 32'(last_hs), 32'(c0 + 5));
    checkOutput("b4_done_cycle", 32'(done_cyc), 32'(c0 + 6));
    checkOutput("b4_words_read_hold", 32'(words_read), 32'd4);

    // Burst of 6 against a stalled sink: the buffer fills to three and pops stop.
    m_ready = 1'b0;
    loadWords(6);
    applyStimulus(6);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall_pop_count", 32'(rd_cnt), 32'd3);
    checkOutput("stall_rd_en_low", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("stall_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("stall_word0", m_data, exp_mem[exp_rd]);
    m_ready = 1'b1;
    waitDone(60);
    checkOutput("stall_total_pops", 32'(rd_cnt), 32'd6);
    checkOutput("stall_total_hs", 32'(hs_cnt), 32'd6);

    // FIFO runs dry after two of five words, then refills.
    loadWords(2);
    applyStimulus(5);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("empty_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      checkOutput("empty_busy", {31'b0, busy}, 32'd1);
    end
    checkOutput("empty_pops_before_refill", 32'(rd_cnt), 32'd2);
    loadWords(3);
    waitDone(60);
    checkOutput("refill_hs", 32'(hs_cnt), 32'd5);

    // Zero-length burst completes immediately without touching the FIFO.
    applyStimulus(0);
    checkOutput("zero_done", {31'b0, done}, 32'd1);
    checkOutput("zero_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("zero_words_read", 32'(words_read), 32'd0);
    waitDone(10);
    checkOutput("zero_pops", 32'(rd_cnt), 32'd0);

    // A second start while busy must not change the burst length.
    loadWords(3);
    applyStimulus(3);
    start = 1'b1; burst_len = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(60);
    checkOutput("ignored_start_pops", 32'(rd_cnt), 32'd3);
    checkOutput("ignored_start_words", 32'(words_read), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ignored_start_idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset in the middle of an 8-word burst.
    loadWords(8);
    applyStimulus(8);
    n = 0;
    while (hs_cnt < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt < 2) failNow("reset_burst_progress");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("abort_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_words_read", 32'(words_read), 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    loadWords(1);
    applyStimulus(1);
    waitDone(30);
    checkOutput("after_reset_hs", 32'(hs_cnt), 32'd1);

    // Random bursts with a trickling FIFO and a bursty sink.
    for (int b = 0; b < 20; b++) begin
      len_r  = $urandom_range(0, 12);
      loaded = 0;
      applyStimulus(len_r);
      n = 0;
      while (done_cnt < done_target && n < 400) begin
        @(posedge clk); #1;
        m_ready = ($urandom_range(0, 3) != 0);
        if (loaded < len_r && $urandom_range(0, 2) != 0) begin
          loadWords(1);
          loaded++;
        end
        n++;
      end
      if (done_cnt < done_target) failNow("random_done_timeout");
      checkOutput("random_pops", 32'(rd_cnt), 32'(len_r));
      checkOutput("random_hs", 32'(hs_cnt), 32'(len_r));
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
